// File: rtl/ifstage_pkg.sv
// rtl/ifstage_pkg.sv - shared types and constants for the instruction-fetch stage
package ifstage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  localparam logic [31:0] PC_INC   = 32'd4;
  localparam int          BR_SHIFT = 2;

  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] immed);
    return pc + PC_INC + (immed << BR_SHIFT);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - instruction queue holding {pc, instr} entries with a registered head
module ifq_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [63:0]              din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [63:0]              head,
  output logic                     valid
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)          wr_ptr <= wr_ptr + 1'b1;
      if (pop && valid)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign count = wr_ptr - rd_ptr;
  assign valid = (wr_ptr != rd_ptr);
  assign head  = valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: rtl/ifstage_prefetch.sv
// rtl/ifstage_prefetch.sv - fetch stage: PC, memory req/ack FSM and instruction queue
module ifstage_prefetch
  import ifstage_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        reset,
  output logic        Mem_req,
  output logic [31:0] Mem_addr,
  input  logic        Mem_ack,
  input  logic [31:0] Mem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  output logic        Instr_valid,
  input  logic        Instr_ready,
  input  logic        PC_sel,
  input  logic [31:0] PC_Immed
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_V = (CW + 1)'(DEPTH);

  fetch_state_t  state, state_n;
  logic [31:0]   pc, pc_n;
  logic [31:0]   addr, addr_n;
  logic [CW-1:0] count;
  logic [63:0]   head;
  logic          valid;
  logic          flush, pop, ack_accept, push, space;
  logic [CW:0]   occupancy;
  logic [31:0]   target;

  assign flush      = valid & PC_sel;
  assign pop        = valid & (Instr_ready | PC_sel);
  assign ack_accept = Mem_ack & (state == WAIT);
  assign push       = ack_accept & ~flush;
  assign target     = branch_target(head[63:32], PC_Immed);

  // Occupancy after this edge; a new request is only issued if it still leaves a free slot.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, ack_accept} - {{CW{1'b0}}, pop};
  assign space      = occupancy < DEPTH_V;

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (Clk),
    .rst_n (reset),
    .push  (push),
    .din   ({addr, Mem_rdata}),
    .pop   (pop),
    .flush (flush),
    .count (count),
    .head  (head),
    .valid (valid)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      addr  <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      addr  <= addr_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    addr_n  = addr;
    case (state)
      IDLE: begin
        if (flush) begin
          pc_n = target;
        end else if (space) begin
          state_n = WAIT;
          addr_n  = pc;
        end
      end
      WAIT: begin
        if (flush) begin
          pc_n = target;
          // An issued request cannot be withdrawn; wait out its ack in DROP.
          if (Mem_ack) addr_n  = target;
          else         state_n = DROP;
        end else if (Mem_ack) begin
          pc_n = addr + PC_INC;
          if (space) addr_n  = addr + PC_INC;
          else       state_n = IDLE;
        end
      end
      DROP: begin
        if (flush) pc_n = target;
        if (Mem_ack) begin
          state_n = WAIT;
          addr_n  = flush ? target : pc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign Mem_req     = (state != IDLE);
  assign Mem_addr    = addr;
  assign Instr_valid = valid;
  assign Instr       = head[31:0];
  assign Instr_PC    = head[63:32];

endmodule

// File: tb/tb_ifstage_prefetch.sv
// tb/tb_ifstage_prefetch.sv - self-checking bench for ifstage_prefetch
module tb_ifstage_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

  logic        Clk = 1'b0;
  logic        reset;
  logic        Mem_req;
  logic [31:0] Mem_addr;
  logic        Mem_ack;
  logic [31:0] Mem_rdata;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        Instr_valid;
  logic        Instr_ready;
  logic        PC_sel;
  logic [31:0] PC_Immed;

  always #5 Clk = ~Clk;

  ifstage_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .Clk         (Clk),
    .reset       (reset),
    .Mem_req     (Mem_req),
    .Mem_addr    (Mem_addr),
    .Mem_ack     (Mem_ack),
    .Mem_rdata   (Mem_rdata),
    .Instr       (Instr),
    .Instr_PC    (Instr_PC),
    .Instr_valid (Instr_valid),
    .Instr_ready (Instr_ready),
    .PC_sel      (PC_sel),
    .PC_Immed    (PC_Immed)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic        ack;
    logic        ready;
    logic        sel;
    logic [31:0] imm;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [23];

  // Reference model state for the random phase
  logic [31:0] q[$];
  logic [31:0] nf;
  logic        drop;
  logic        s_req, s_ack, s_ready, s_sel;
  logic [31:0] s_addr, s_imm;
  int          wcnt, lat, idle_run;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h4};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h4};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'h4};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h4};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h14,       1'b1, 32'h8};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h18,       1'b1, 32'hC};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h18,      1'b1, 32'h10};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h18,       1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h18,       1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b0, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'hC};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       1'b0, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 32'h10,       1'b1, 32'h14,       1'b1, 32'h10};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h54,       1'b0, 32'h0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFE8, 1'b1, 32'h58,      1'b1, 32'h54};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h58,       1'b0, 32'h0};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'hFFFF_FFFC};
    tbl[22] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};

    reset = 1'b0; Mem_ack = 1'b0; Mem_rdata = '0;
    Instr_ready = 1'b0; PC_sel = 1'b0; PC_Immed = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("rst_req",   Mem_req, 0);
      chk("rst_valid", Instr_valid, 0);
      chk("rst_instr", Instr, 0);
      chk("rst_pc",    Instr_PC, 0);
    end
    @(posedge Clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 23; i++) begin
      Mem_ack     = tbl[i].ack;
      Instr_ready = tbl[i].ready;
      PC_sel      = tbl[i].sel;
      PC_Immed    = tbl[i].imm;
      Mem_rdata   = Mem_addr ^ KEY;
      @(negedge Clk);
      chk($sformatf("v%0d_req", i), Mem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), Mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_valid", i), Instr_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_ipc", i),   Instr_PC, tbl[i].e_pc);
        chk($sformatf("v%0d_instr", i), Instr, tbl[i].e_pc ^ KEY);
      end
      @(posedge Clk); #1;
    end

    // Two entries queued with a request outstanding, then reset asynchronously.
    PC_sel = 1'b0; Instr_ready = 1'b0; Mem_ack = 1'b1;
    Mem_rdata = Mem_addr ^ KEY;
    @(posedge Clk); #1;
    Mem_rdata = Mem_addr ^ KEY;
    @(posedge Clk); #1;
    Mem_ack = 1'b0;
    @(negedge Clk);
    chk("mid_valid_before", Instr_valid, 1);
    chk("mid_req_before",   Mem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req",   Mem_req, 0);
    chk("mid_rst_valid", Instr_valid, 0);
    chk("mid_rst_instr", Instr, 0);
    @(posedge Clk); #1;
    reset = 1'b1;
    @(negedge Clk);
    chk("post_rst_req",  Mem_req, 0);
    chk("post_rst_addr", Mem_addr, 0);

    q.delete(); nf = 32'h0; drop = 1'b0;
    s_req = Mem_req; s_ack = 1'b0; s_addr = Mem_addr; s_ready = 1'b0; s_sel = 1'b0; s_imm = '0;
    wcnt = 0; lat = $urandom_range(1, 4); idle_run = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        m_valid, flush, pop, do_push;
      logic [31:0] head_pc, push_pc;
      @(posedge Clk);
      m_valid = (q.size() != 0);
      head_pc = m_valid ? q[0] : 32'h0;
      flush   = m_valid && s_sel;
      pop     = m_valid && (s_ready || s_sel);
      do_push = 1'b0;
      push_pc = nf;
      if (s_req && s_ack) begin
        if (!drop && !flush) begin
          chk("fetch_addr", s_addr, nf);
          do_push = 1'b1;
          nf = nf + 32'd4;
        end
        drop = 1'b0;
      end
      if (pop && !flush) void'(q.pop_front());
      if (do_push) begin
        q.push_back(push_pc);
        chk("no_overflow", q.size() <= DEPTH, 1);
      end
      if (flush) begin
        q.delete();
        nf = head_pc + 32'd4 + (s_imm << 2);
        if (s_req && !s_ack) drop = 1'b1;
      end
      if (s_req && s_ack) begin
        wcnt = 0;
        lat  = $urandom_range(1, 4);
      end else if (s_req) begin
        wcnt++;
      end

      #1;
      Mem_ack     = Mem_req && (wcnt >= lat - 1);
      Mem_rdata   = Mem_addr ^ KEY;
      Instr_ready = ($urandom_range(0, 3) != 0);
      PC_sel      = (q.size() != 0) && ($urandom_range(0, 15) == 0);
      PC_Immed    = 32'($urandom_range(0, 63)) - 32'd32;

      @(negedge Clk);
      if (cyc == 0) begin
        chk("first_fetch_req",  Mem_req, 1);
        chk("first_fetch_addr", Mem_addr, 0);
      end
      chk("rnd_valid", Instr_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rnd_ipc",   Instr_PC, q[0]);
        chk("rnd_instr", Instr, q[0] ^ KEY);
      end
      if (s_req && !s_ack) begin
        chk("hold_req",  Mem_req, 1);
        chk("hold_addr", Mem_addr, s_addr);
      end
      if (!Mem_req && q.size() < DEPTH) idle_run++;
      else idle_run = 0;
      chk("liveness", idle_run > 2, 0);

      s_req = Mem_req; s_ack = Mem_ack; s_addr = Mem_addr;
      s_ready = Instr_ready; s_sel = PC_sel; s_imm = PC_Immed;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ifstage_prefetch.md
Name: ifstage_prefetch

Overview:
- Instruction-fetch stage sitting directly upstream of the decode stage.
- Holds the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake with variable latency.
- Buffers fetched words in a small FIFO and presents them to decode as the `Instr` word plus its address.
- Handles taken branches (`PC_sel`/`PC_Immed`) by flushing and redirecting the PC.

Parameters:
- DEPTH, 4, instruction-queue entries (power of 2, ≥2)
- RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
- Clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Mem_req  out  1  fetch request valid
- Mem_addr  out  32  fetch address, word aligned
- Mem_ack  in  1  memory response valid; meaningful only while Mem_req=1
- Mem_rdata  in  32  instruction word, valid with Mem_ack
- Instr  out  32  head instruction to decode
- Instr_PC  out  32  address of Instr
- Instr_valid  out  1  head entry valid
- Instr_ready  in  1  decode consumes head this cycle
- PC_sel  in  1  taken branch for the head instruction; legal only when Instr_valid=1
- PC_Immed  in  32  sign-extended 16-bit branch immediate from decode

Behaviour:
- **Reset (reset=0, asynchronous)**
  - Fetch PC=RESET_PC, FIFO empty.
  - State=IDLE, Mem_req=0, Mem_addr=RESET_PC.
  - Instr_valid=0, Instr=0, Instr_PC=0.
- **Handshake**
  - Mem_req, Mem_addr are registered and held stable until the cycle Mem_ack=1.
  - Ack may arrive in the first cycle Mem_req is high (minimum latency 1).
  - At most one request outstanding.
- **Free-slot rule**
  - space = count + ack_accept − pop < DEPTH, evaluated every edge.
  - ack_accept = Mem_ack & (state==WAIT).
  - pop = Instr_valid & (Instr_ready | PC_sel).
- **FSM states: IDLE, WAIT, DROP**
  - IDLE: if space → WAIT, Mem_req=1, Mem_addr=PC.
  - WAIT, no ack, no flush: hold.
  - WAIT, ack, no flush:
    - push {Mem_rdata, Mem_addr}; PC=Mem_addr+4.
    - If space: stay WAIT with Mem_addr=Mem_addr+4 (back-to-back, one instruction/cycle at zero wait).
    - Else → IDLE, Mem_req=0.
  - WAIT, flush, ack same cycle: rdata discarded; → WAIT, Mem_addr=target.
  - WAIT, flush, no ack: → DROP; Mem_req stays high, because a request cannot be cancelled.
  - DROP, ack: rdata discarded; → WAIT, Mem_addr=target held in the PC register.
  - IDLE, flush: PC=target; next edge → WAIT.
- **Output timing**
  - FIFO output is registered; a pushed word is visible on Instr no earlier than the cycle after its ack.
  - There is no bypass, so fetch-to-decode latency is ack + 1 cycle.
- **Flush (PC_sel=1 with Instr_valid=1)**
  - target = Instr_PC + 4 + (PC_Immed << 2), modulo 2^32 (wrap-around silently).
  - All FIFO entries, including the head, are discarded at that edge; Instr_valid=0 next cycle.
  - A flush overrides any push in the same cycle.
- **Head consumption**
  - Pop with Instr_ready=1 and Instr_valid=1 advances the head.
  - When the FIFO is full and decode pops while an ack arrives, push and pop occur together and count is unchanged.
- **Illegal input**
  - PC_sel with Instr_valid=0 is ignored; decode guarantees it cannot occur.
- **Stable outputs**
  - Instr and Instr_PC hold their values while Instr_valid=1 and Instr_ready=0.
- **FIFO wrap**
  - Pointers are log2(DEPTH)+1 bits: full when MSBs differ and LSBs are equal; empty when the pointers are equal.
- **PC width**
  - PC increments by 4 and wraps at 32'hFFFF_FFFC → 0.

Decomposition:
- Package ifstage_pkg holds:
  - fetch_state_t enum {IDLE, WAIT, DROP}
  - PC_INC = 32'd4
  - BR_SHIFT = 2
- Sub-module ifq_fifo:
  - Parameterised DEPTH, 64-bit entry {pc, instr}.
  - Inputs push, pop, flush; outputs count, head, valid.
  - The FSM and PC logic stay in the top.

Test Plan:
- **Reset:** hold reset=0 for 3 cycles, then release → Mem_req=1 within 2 edges, Mem_addr=0x0; Instr_valid=0 throughout reset.
- **Zero-wait stream:** Mem_ack tied 1, rdata=addr^0xA5A5A5A5, Instr_ready=1 → Mem_addr 0,4,8,… one per cycle; Instr_PC follows one cycle behind the ack; Instr matches.
- **Backpressure:** Instr_ready=0, zero-wait memory → exactly 4 pushes (PC 0x0–0xC), then Mem_req=0. Raise Instr_ready → one pop per cycle and requests resume at 0x10 without loss or duplication.
- **Branch at head:** Instr_PC=0x8, PC_sel=1, PC_Immed=0xFFFF_FFFE → target 0x4, FIFO emptied, next Mem_addr=0x4, first valid Instr_PC=0x4.
- **Flush with outstanding request:** ack delayed 3 cycles, PC_sel issued while waiting, PC_Immed=0x10 at Instr_PC=0x20 → stale rdata dropped (never appears on Instr), then Mem_addr=0x64.
- **Mid-operation reset:** assert reset=0 asynchronously while in WAIT with 2 entries queued → Mem_req=0, Instr_valid=0 immediately; after release the first fetch goes to RESET_PC.
